dmem_access_unit: RTL and testbench

MEM-stage data-memory access unit, directly downstream of the pipelined core's EX/MEM register. It consumes the core's memory outputs (op, read/write, address, store data) and drives a valid/ready word-wide data bus with byte strobes. It returns the aligned and extended load data on the core's read-data input, and asserts stall to freeze the pipeline while a bus transaction is outstanding.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 68 ++++++
 rtl/dmem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_dmem_access_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// MemOp (func3) encodings, FSM state encoding, counter and strobe widths.
package dmem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam int CNT_W  = 8;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // 011, 110 and 111 have no meaning as a memory access
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_B, OP_H, OP_W, OP_BU, OP_HU: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data replication and strobes,
// load byte/halfword extraction with sign/zero extension, misalign detect.
// Halfword and word lane selection only looks at the address bits that
// matter for that size, so a misaligned address is naturally rounded down.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [1:0]        i_addr_lo,
    input  logic [31:0]       i_store_data,
    input  logic [31:0]       i_read_word,
    output logic [31:0]       o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [31:0]       o_load_data,
    output logic              o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_read_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_read_word[{i_addr_lo[1], 4'b0000} +: 16];

    // Per-size store lanes, load extension and alignment check
    always_comb begin
        o_wdata     = '0;
        o_wstrb     = '0;
        o_load_data = '0;
        o_misalign  = 1'b0;
        case (i_op)
            OP_B: begin
                o_wdata     = {4{i_store_data[7:0]}};
                o_wstrb     = 4'b0001 << i_addr_lo;
                o_load_data = {{24{w_byte[7]}}, w_byte};
            end
            OP_BU: begin
                o_wdata     = {4{i_store_data[7:0]}};
                o_wstrb     = 4'b0001 << i_addr_lo;
                o_load_data = {24'd0, w_byte};
            end
            OP_H: begin
                o_wdata     = {2{i_store_data[15:0]}};
                o_wstrb     = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_load_data = {{16{w_half[15]}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            OP_HU: begin
                o_wdata     = {2{i_store_data[15:0]}};
                o_wstrb     = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_load_data = {16'd0, w_half};
                o_misalign  = i_addr_lo[0];
            end
            OP_W: begin
                o_wdata     = i_store_data;
                o_wstrb     = 4'b1111;
                o_load_data = i_read_word;
                o_misalign  = (i_addr_lo != 2'b00);
            end
            default: begin
                o_wdata     = '0;
                o_wstrb     = '0;
                o_load_data = '0;
                o_misalign  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: turns EX/MEM load/store requests into
// valid/ready bus transactions, stalls the pipeline while one is in flight,
// and returns extended load data. Optional build macro
// DMEM_MISALIGN_TRAP_EN: when defined, misaligned H/HU/W accesses fault
// instead of being rounded down to their natural alignment.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mem_op,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       mem_data_in,
    output logic [31:0]       mem_read_data_out,
    output logic              stall,
    output logic              err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic MISALIGN_TRAP = 1'b1;
`else
    localparam logic MISALIGN_TRAP = 1'b0;
`endif

    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_we;
    logic                r_fault;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [31:0]         r_rdata_out;
    logic [2:0]          r_op;
    logic [1:0]          r_addr_lo;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_req;
    logic                w_fault_req;
    logic [CNT_W:0]      w_cnt_inc;
    logic                w_timeout;
    logic [2:0]          w_lane_op;
    logic [1:0]          w_lane_addr;
    logic [31:0]         w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic [31:0]         w_load_data;
    logic                w_misalign;

    assign w_req       = mem_read | mem_write;
    assign w_fault_req = (mem_read & mem_write) | ~op_is_legal(mem_op)
                       | (MISALIGN_TRAP & w_misalign);
    assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
    assign w_timeout   = (w_cnt_inc >= TIMEOUT_LIM);

    // In IDLE the lanes are steered from the live request; afterwards from
    // the latched op/offset so load extraction matches the issued access.
    assign w_lane_op   = (r_state == ST_IDLE) ? mem_op : r_op;
    assign w_lane_addr = (r_state == ST_IDLE) ? data_addr[1:0] : r_addr_lo;

    dmem_lane_align u_lane_align (
        .i_op         (w_lane_op),
        .i_addr_lo    (w_lane_addr),
        .i_store_data (mem_data_in),
        .i_read_word  (bus_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; a handshake or data beat wins over a same-cycle timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) w_state_next = w_fault_req ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                if (bus_ready)      w_state_next = r_we ? ST_DONE : ST_RESP;
                else if (w_timeout) w_state_next = ST_DONE;
            end
            ST_RESP: begin
                if (bus_rvalid || w_timeout) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Decoded outputs: bus request, pipeline freeze and one-cycle fault pulse
    always_comb begin
        bus_valid = (r_state == ST_REQ);
        stall     = ((r_state == ST_IDLE) & w_req)
                  | (r_state == ST_REQ) | (r_state == ST_RESP);
        err       = (r_state == ST_DONE) & r_fault;
    end

    // Request latching, timeout counter and load-result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_fault     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata_out <= '0;
            r_op        <= '0;
            r_addr_lo   <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_fault   <= w_fault_req;
                        r_op      <= mem_op;
                        r_addr_lo <= data_addr[1:0];
                        if (!w_fault_req) begin
                            r_we    <= mem_write;
                            r_addr  <= {data_addr[ADDR_W-1:2], 2'b00};
                            r_wdata <= mem_write ? w_wdata : '0;
                            r_wstrb <= mem_write ? w_wstrb : '0;
                        end
                    end
                end
                ST_REQ: begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                    if (!bus_ready && w_timeout) begin
                        r_fault <= 1'b1;
                        if (!r_we) r_rdata_out <= '0;
                    end
                end
                ST_RESP: begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                    if (bus_rvalid) begin
                        r_rdata_out <= w_load_data;
                    end else if (w_timeout) begin
                        r_fault     <= 1'b1;
                        r_rdata_out <= '0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus_we            = r_we;
    assign bus_addr          = r_addr;
    assign bus_wdata         = r_wdata;
    assign bus_wstrb         = r_wstrb;
    assign mem_read_data_out = r_rdata_out;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver pushes expected bus
// requests and completions into queues, a negedge monitor pops and compares.
module tb_dmem_access_unit;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  mem_op = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] mem_data_in = '0;
    logic [31:0] mem_read_data_out;
    logic        stall;
    logic        err;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT), .ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_op            (mem_op),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .data_addr         (data_addr),
        .mem_data_in       (mem_data_in),
        .mem_read_data_out (mem_read_data_out),
        .stall             (stall),
        .err               (err),
        .bus_valid         (bus_valid),
        .bus_ready         (bus_ready),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_wstrb         (bus_wstrb),
        .bus_rvalid        (bus_rvalid),
        .bus_rdata         (bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } bus_exp_t;

    typedef struct {
        int          stalls;
        logic        err;
        logic [31:0] rd;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_txn   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] s);
        bus_exp_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.strb = s;
        bus_q.push_back(e);
    endtask

    task automatic push_done(input int st, input logic e, input logic [31:0] rd);
        done_exp_t d;
        d.stalls = st; d.err = e; d.rd = rd;
        done_q.push_back(d);
    endtask

    // Core + bus-slave model. ready_wait: REQ cycles before bus_ready;
    // rvalid_wait: idle RESP cycles before bus_rvalid; abort_at: RESP cycle
    // index at which reset is pulled low (-1 = never).
    task automatic access(input logic [2:0] op, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] d,
                          input int ready_wait, input int rvalid_wait,
                          input logic [31:0] rdata, input int abort_at);
        int req_cnt  = 0;
        int resp_cnt = 0;
        bit accepted = 0;
        bit done     = 0;
        @(posedge clk); #1;
        mem_op = op; mem_read = rd; mem_write = wr; data_addr = addr; mem_data_in = d;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge clk); #1;
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom();
            if (!stall) begin
                done = 1;
            end else if (bus_valid) begin
                if (req_cnt == ready_wait) begin
                    bus_ready = 1'b1;
                    accepted  = 1;
                end
                req_cnt++;
            end else if (accepted) begin
                if (resp_cnt == abort_at) begin
                    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
                end else if (resp_cnt == rvalid_wait) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                end
                resp_cnt++;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!done) check("drv_cycle_bound", 32'(stall), 32'd0);
    endtask

    // Monitor: compares bus request fields every valid cycle, and each
    // completed stall window against the expected completion.
    int  stall_run = 0;
    bit  pend_unacc = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus_valid) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_valid", 32'(bus_valid), 32'd0);
                end else begin
                    check("bus_addr",  bus_addr,         bus_q[0].addr);
                    check("bus_we",    32'(bus_we),      32'(bus_q[0].we));
                    check("bus_wdata", bus_wdata,        bus_q[0].wdata);
                    check("bus_wstrb", 32'(bus_wstrb),   32'(bus_q[0].strb));
                    if (bus_ready) begin
                        void'(bus_q.pop_front());
                        pend_unacc = 0;
                    end else begin
                        pend_unacc = 1;
                    end
                end
            end else if (pend_unacc) begin
                void'(bus_q.pop_front());
                pend_unacc = 0;
            end

            if (stall) begin
                stall_run++;
                if (err) check("err_during_stall", 32'(err), 32'd0);
            end else if (stall_run > 0) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(stall_run), 32'd0);
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    n_txn++;
                    $display("txn %0d: stall_cycles=%0d err=%0b rdata=%08h (want %0d/%0b/%08h)",
                             n_txn, stall_run, err, mem_read_data_out, e.stalls, e.err, e.rd);
                    check("stall_cycles", 32'(stall_run), 32'(e.stalls));
                    check("err_pulse",    32'(err),       32'(e.err));
                    check("read_data",    mem_read_data_out, e.rd);
                end
                stall_run = 0;
            end else if (err) begin
                check("err_outside_done", 32'(err), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_we",    32'(bus_we),    32'd0);
        check("rst_bus_addr",  bus_addr,       32'd0);
        check("rst_bus_wdata", bus_wdata,      32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_rdata",     mem_read_data_out, 32'd0);
        check("rst_stall",     32'(stall),     32'd0);

        // Store byte, offset 3
        push_bus(32'h100, 1, 32'hA5A5A5A5, 4'b1000); push_done(2, 0, 32'h0);
        access(3'b000, 0, 1, 32'h103, 32'h000000A5, 0, 0, 0, -1);
        // Load signed half, upper lane, rvalid two cycles after acceptance
        push_bus(32'h200, 0, 0, 4'b0000); push_done(4, 0, 32'hFFFF8001);
        access(3'b001, 1, 0, 32'h202, 0, 0, 1, 32'h80011234, -1);
        // Load word with three ready wait states
        push_bus(32'h30C, 0, 0, 4'b0000); push_done(6, 0, 32'hDEADBEEF);
        access(3'b010, 1, 0, 32'h30C, 0, 3, 0, 32'hDEADBEEF, -1);
        // Misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
        push_done(1, 1, 32'hDEADBEEF);
`else
        push_bus(32'h4, 0, 0, 4'b0000); push_done(3, 0, 32'h11223344);
`endif
        access(3'b010, 1, 0, 32'h6, 0, 0, 0, 32'h11223344, -1);
        // Byte/half load extensions
        push_bus(32'h400, 0, 0, 4'b0000); push_done(3, 0, 32'h000000F6);
        access(3'b100, 1, 0, 32'h401, 0, 0, 0, 32'h1234F678, -1);
        push_bus(32'h400, 0, 0, 4'b0000); push_done(3, 0, 32'hFFFFFF80);
        access(3'b000, 1, 0, 32'h402, 0, 0, 0, 32'h00800000, -1);
        push_bus(32'h0, 0, 0, 4'b0000); push_done(5, 0, 32'h00009ABC);
        access(3'b101, 1, 0, 32'h0, 0, 0, 2, 32'h00009ABC, -1);
        // Stores: load result must hold
        push_bus(32'h10, 1, 32'hBEEFBEEF, 4'b1100); push_done(3, 0, 32'h00009ABC);
        access(3'b001, 0, 1, 32'h12, 32'h0000BEEF, 1, 0, 0, -1);
        push_bus(32'h20, 1, 32'hCAFEF00D, 4'b1111); push_done(2, 0, 32'h00009ABC);
        access(3'b010, 0, 1, 32'h20, 32'hCAFEF00D, 0, 0, 0, -1);
        push_bus(32'h0, 1, 32'h77777777, 4'b0001); push_done(2, 0, 32'h00009ABC);
        access(3'b000, 0, 1, 32'h0, 32'h12345677, 0, 0, 0, -1);
        // Faults: read+write, illegal ops
        push_done(1, 1, 32'h00009ABC);
        access(3'b010, 1, 1, 32'h8, 0, 0, 0, 0, -1);
        push_done(1, 1, 32'h00009ABC);
        access(3'b011, 1, 0, 32'h8, 0, 0, 0, 0, -1);
        push_done(1, 1, 32'h00009ABC);
        access(3'b110, 0, 1, 32'h8, 32'h1, 0, 0, 0, -1);
        // Timeouts with bus_ready held low
        push_bus(32'h44, 1, 32'h55AA55AA, 4'b1111); push_done(1 + TB_TIMEOUT, 1, 32'h00009ABC);
        access(3'b010, 0, 1, 32'h44, 32'h55AA55AA, 999, 0, 0, -1);
        push_bus(32'h40, 0, 0, 4'b0000); push_done(1 + TB_TIMEOUT, 1, 32'h0);
        access(3'b010, 1, 0, 32'h40, 0, 999, 0, 0, -1);
        push_bus(32'h48, 0, 0, 4'b0000); push_done(3, 0, 32'h13579BDF);
        access(3'b010, 1, 0, 32'h48, 0, 0, 0, 32'h13579BDF, -1);
        // Reset in second RESP cycle, then a late rvalid in IDLE
        push_bus(32'h50, 0, 0, 4'b0000); push_done(4, 0, 32'h0);
        access(3'b010, 1, 0, 32'h50, 0, 0, 999, 0, 1);
        reset      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        check("late_rvalid_rdata", mem_read_data_out, 32'd0);
        check("late_rvalid_stall", 32'(stall),        32'd0);
        check("late_rvalid_valid", 32'(bus_valid),    32'd0);
        check("abort_bus_addr",    bus_addr,          32'd0);
        // Misaligned halfword after recovery
`ifdef DMEM_MISALIGN_TRAP_EN
        push_done(1, 1, 32'h0);
`else
        push_bus(32'h200, 0, 0, 4'b0000); push_done(3, 0, 32'hFFFFC0DE);
`endif
        access(3'b001, 1, 0, 32'h203, 0, 0, 0, 32'hC0DE0000, -1);

        repeat (3) @(posedge clk);
        #1;
        check("bus_q_drained",  32'(bus_q.size()),  32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
